obi_rom_pipe: RTL and testbench

- Parametrised read-only OBI subordinate for the user domain. Generalises the single-cycle user ROM.
- Word depth and word contents are set by parameters, and response latency is configurable.
- Back-to-back requests are fully pipelined; out-of-range reads and writes return errors; reads honour byte enables.
- Sits behind the user-domain OBI demux as a constant/ID store, for example a chip signature string.

---
 rtl/obi_rom_pipe.sv | 176 +++++++++++++++++
 tb/tb_obi_rom_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_rom_pipe.sv
`default_nettype none
// ============================================================================
// Module      : obi_rom_pipe (with companion package obi_pkg)
// Description : Read-only OBI subordinate with a parameter-defined ROM image
//               and a configurable, fully pipelined response latency.
//               Writes and out-of-range reads answer with err=1. Reads honour
//               the byte enables.
// Revision    : 1.0 - initial release
// ============================================================================

package obi_pkg;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 4};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [3:0]  aid;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [3:0]  rid;
        logic        err;
        logic        r_optional;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

endpackage

module obi_rom_pipe #(
    parameter obi_pkg::obi_cfg_t         ObiCfg   = obi_pkg::ObiDefaultConfig,
    parameter type                       obi_req_t = obi_pkg::obi_req_t,
    parameter type                       obi_rsp_t = obi_pkg::obi_rsp_t,
    parameter int unsigned               NumWords = 8,
    parameter int unsigned               Latency  = 2,
    parameter logic [NumWords-1:0][31:0] Contents = '0
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  obi_req_t obi_req_i,
    output obi_rsp_t obi_rsp_o
);

    // Word index width; a single-word ROM still decodes one address bit so
    // that word 1 of a one-word ROM is reported as out of range.
    localparam int unsigned c_idx_w = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int unsigned c_id_w  = $bits(obi_req_i.a.aid);
    localparam logic [c_idx_w:0] c_num_words = NumWords[c_idx_w:0];

    // ------------------------------------------------------------------------
    // Elaboration-time configuration checks
    // ------------------------------------------------------------------------
    if (ObiCfg.DataWidth != 32) begin : g_chk_data_width
        $error("obi_rom_pipe: ObiCfg.DataWidth must be 32");
    end

    if ((Latency < 1) || (Latency > 8)) begin : g_chk_latency
        $error("obi_rom_pipe: Latency must be within 1..8");
    end

    if ((NumWords < 1) || (NumWords > 256)) begin : g_chk_num_words
        $error("obi_rom_pipe: NumWords must be within 1..256");
    end

    // One pipeline slot; an empty slot carries all-zero payload so the
    // response fields read as zero whenever rvalid is low.
    typedef struct packed {
        logic              valid;
        logic [c_id_w-1:0] id;
        logic [31:0]       data;
        logic              err;
    } stage_t;

    logic [c_idx_w-1:0] w_idx;
    logic               w_oob;
    logic [31:0]        w_word;
    logic [31:0]        w_s0_data;
    logic               w_s0_err;
    stage_t             w_stage_in;
    stage_t             r_stage [Latency];
    logic               w_unused;

    // Word index comes from the word-aligned address bits only.
    assign w_idx = obi_req_i.a.addr[2 +: c_idx_w];
    assign w_oob = {1'b0, w_idx} >= c_num_words;

    // Byte lanes and upper address bits play no part in the lookup.
    assign w_unused = ^{obi_req_i.a.wdata,
                        obi_req_i.a.addr[1:0],
                        obi_req_i.a.addr[31:2+c_idx_w]};

    // Stage-0 lookup: error for writes or out-of-range words, else masked word.
    always_comb begin
        w_word    = '0;
        w_s0_data = '0;
        w_s0_err  = 1'b0;
        if (obi_req_i.a.we || w_oob) begin
            w_s0_err = 1'b1;
        end else begin
            w_word = Contents[w_idx];
            for (int k = 0; k < 4; k++) begin
                if (obi_req_i.a.be[k]) begin
                    w_s0_data[8*k +: 8] = w_word[8*k +: 8];
                end
            end
        end
    end

    // Pack the accepted request into a slot; no request gives an empty slot.
    always_comb begin
        w_stage_in = '0;
        if (obi_req_i.req) begin
            w_stage_in.valid = 1'b1;
            w_stage_in.id    = obi_req_i.a.aid;
            w_stage_in.data  = w_s0_data;
            w_stage_in.err   = w_s0_err;
        end
    end

    // ------------------------------------------------------------------------
    // Response pipeline: a plain shift chain, one slot per latency cycle.
    // ------------------------------------------------------------------------
    for (genvar s = 0; s < Latency; s++) begin : g_stage
        if (s == 0) begin : g_first
            // First slot captures the incoming request every cycle.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_stage[0] <= '0;
                end else begin
                    r_stage[0] <= w_stage_in;
                end
            end
        end else begin : g_next
            // Later slots advance the previous slot unconditionally.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_stage[s] <= '0;
                end else begin
                    r_stage[s] <= r_stage[s-1];
                end
            end
        end
    end

    // Grant follows req directly; the response comes straight from the last slot.
    always_comb begin
        obi_rsp_o         = '0;
        obi_rsp_o.gnt     = obi_req_i.req;
        obi_rsp_o.rvalid  = r_stage[Latency-1].valid;
        obi_rsp_o.r.rdata = r_stage[Latency-1].data;
        obi_rsp_o.r.rid   = r_stage[Latency-1].id;
        obi_rsp_o.r.err   = r_stage[Latency-1].err;
    end

endmodule

`default_nettype wire

// File: tb/tb_obi_rom_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_obi_rom_pipe
// Description : Self-checking bench for obi_rom_pipe. Several instances with
//               different Latency/NumWords run side by side. A directed vector
//               table, a reset-in-flight sequence and random traffic feed a
//               per-instance scoreboard of expected responses.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_obi_rom_pipe;

    localparam int c_ncfg = 10;
    localparam int c_lat [c_ncfg] = '{2, 3, 4, 1, 1, 8, 5, 6, 7, 8};
    localparam int c_nw  [c_ncfg] = '{8, 8, 5, 1, 7, 256, 7, 256, 1, 8};

    // ROM image used by every instance; words 0 and 1 form a signature.
    function automatic logic [31:0] word_of(int i, int n);
        if (i == 0) return 32'h4A616B75;
        if (i == 1) return 32'h6220616E;
        return {8'hC5, 8'(n), 8'hE1, 8'(i)};
    endfunction

    function automatic logic [255:0][31:0] img_of(int n);
        logic [255:0][31:0] img;
        img = '0;
        for (int i = 0; i < 256; i++) img[i] = word_of(i, n);
        return img;
    endfunction

    // Reference behaviour: {err, rdata} for one request.
    function automatic logic [32:0] model(int g, logic we, logic [31:0] addr, logic [3:0] be);
        int          n;
        int          idxw;
        int          idx;
        logic [31:0] w;
        logic [31:0] d;
        n    = c_nw[g];
        idxw = (n <= 2) ? 1 : $clog2(n);
        idx  = int'((addr >> 2) & ((32'd1 << idxw) - 32'd1));
        d    = '0;
        if (we || idx >= n) return {1'b1, 32'h0};
        w = word_of(idx, n);
        for (int k = 0; k < 4; k++) if (be[k]) d[8*k +: 8] = w[8*k +: 8];
        return {1'b0, d};
    endfunction

    typedef struct {
        int unsigned due;
        logic [3:0]  rid;
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        int          g;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [3:0]  aid;
        int          gap;
        logic [31:0] data;
        logic        err;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    obi_pkg::obi_req_t req_a [c_ncfg];
    obi_pkg::obi_rsp_t rsp_a [c_ncfg];
    int unsigned       cyc = 0;
    int                n_vec = 0;
    int                n_err = 0;
    exp_t              sb [c_ncfg][$];
    vec_t              tab [40];
    int                n_tab = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < c_ncfg; g++) begin : g_dut
        localparam logic [255:0][31:0] c_full = img_of(c_nw[g]);
        obi_rom_pipe #(
            .NumWords (c_nw[g]),
            .Latency  (c_lat[g]),
            .Contents (c_full[c_nw[g]-1:0])
        ) u_dut (
            .clk_i     (clk),
            .rst_ni    (rst_n),
            .obi_req_i (req_a[g]),
            .obi_rsp_o (rsp_a[g])
        );
    end

    // Compare every instance on the falling edge, away from the active edge.
    always @(negedge clk) begin : p_mon
        exp_t e;
        logic ev;
        for (int g = 0; g < c_ncfg; g++) begin
            n_vec++;
            if (rsp_a[g].gnt !== req_a[g].req) begin
                n_err++;
                $display("FAIL gnt[%0d] cyc %0d: got %b, want %b", g, cyc, rsp_a[g].gnt, req_a[g].req);
            end
            ev = 1'b0;
            e  = '{default: 0};
            if (sb[g].size() != 0 && sb[g][0].due == cyc) begin
                e  = sb[g].pop_front();
                ev = 1'b1;
            end
            n_vec++;
            if (rsp_a[g].rvalid !== ev || rsp_a[g].r.rid !== e.rid || rsp_a[g].r.rdata !== e.data ||
                rsp_a[g].r.err !== e.err || rsp_a[g].r.r_optional !== 1'b0) begin
                n_err++;
                $display("FAIL rsp[%0d] cyc %0d: got v=%b id=%h d=%h e=%b o=%b, want v=%b id=%h d=%h e=%b o=0",
                         g, cyc, rsp_a[g].rvalid, rsp_a[g].r.rid, rsp_a[g].r.rdata, rsp_a[g].r.err,
                         rsp_a[g].r.r_optional, ev, e.rid, e.data, e.err);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int g = 0; g < c_ncfg; g++) req_a[g] = '0;
    endtask

    // Present one request and log its expected response unless in reset.
    task automatic drive(int g, logic we, logic [31:0] addr, logic [3:0] be, logic [3:0] aid,
                         logic [31:0] edata, logic eerr);
        exp_t e;
        req_a[g].req     = 1'b1;
        req_a[g].a.we    = we;
        req_a[g].a.addr  = addr;
        req_a[g].a.be    = be;
        req_a[g].a.aid   = aid;
        req_a[g].a.wdata = $urandom();
        if (rst_n) begin
            e.due  = cyc + c_lat[g];
            e.rid  = aid;
            e.data = edata;
            e.err  = eerr;
            sb[g].push_back(e);
        end
    endtask

    function automatic void add(int g, logic we, logic [31:0] addr, logic [3:0] be, logic [3:0] aid,
                                int gap, logic [31:0] data, logic err);
        tab[n_tab] = '{g, we, addr, be, aid, gap, data, err};
        n_tab++;
    endfunction

    initial begin
        idle_all();
        #1 rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Instance 0: Latency 2, 8 words
        add(0, 1'b0, 32'h0000_0004, 4'hF,    4'd3, 4, 32'h6220616E, 1'b0);
        add(0, 1'b1, 32'h0000_0008, 4'hF,    4'd5, 4, 32'h00000000, 1'b1);
        add(0, 1'b0, 32'h0000_0008, 4'hF,    4'd6, 4, 32'hC508E102, 1'b0);
        add(0, 1'b0, 32'h0000_0000, 4'b0101, 4'd1, 4, 32'h00610075, 1'b0);
        add(0, 1'b0, 32'h0000_0023, 4'hF,    4'd2, 4, 32'h4A616B75, 1'b0);
        add(0, 1'b0, 32'h0000_001C, 4'b1010, 4'd7, 4, 32'hC500E100, 1'b0);
        // Instance 1: Latency 3, back-to-back sweep of all 8 words
        add(1, 1'b0, 32'h0000_0000, 4'hF, 4'd0, 0, 32'h4A616B75, 1'b0);
        add(1, 1'b0, 32'h0000_0004, 4'hF, 4'd1, 0, 32'h6220616E, 1'b0);
        add(1, 1'b0, 32'h0000_0008, 4'hF, 4'd2, 0, 32'hC508E102, 1'b0);
        add(1, 1'b0, 32'h0000_000C, 4'hF, 4'd3, 0, 32'hC508E103, 1'b0);
        add(1, 1'b0, 32'h0000_0010, 4'hF, 4'd4, 0, 32'hC508E104, 1'b0);
        add(1, 1'b0, 32'h0000_0014, 4'hF, 4'd5, 0, 32'hC508E105, 1'b0);
        add(1, 1'b0, 32'h0000_0018, 4'hF, 4'd6, 0, 32'hC508E106, 1'b0);
        add(1, 1'b0, 32'h0000_001C, 4'hF, 4'd7, 4, 32'hC508E107, 1'b0);
        // Instance 2: Latency 4, 5 words (non power of two)
        add(2, 1'b0, 32'h0000_0014, 4'hF,    4'd4, 0, 32'h00000000, 1'b1);
        add(2, 1'b0, 32'h0000_0000, 4'b0101, 4'd9, 0, 32'h00610075, 1'b0);
        add(2, 1'b0, 32'h0000_0010, 4'hF,    4'd1, 0, 32'hC505E104, 1'b0);
        add(2, 1'b0, 32'h0000_001C, 4'hF,    4'd2, 0, 32'h00000000, 1'b1);
        add(2, 1'b0, 32'h0000_0018, 4'hF,    4'd3, 4, 32'h00000000, 1'b1);
        // Instance 3: Latency 1, single word
        add(3, 1'b0, 32'h0000_0000, 4'hF,    4'd1, 0, 32'h4A616B75, 1'b0);
        add(3, 1'b0, 32'h0000_0004, 4'hF,    4'd2, 0, 32'h00000000, 1'b1);
        add(3, 1'b0, 32'h0000_0008, 4'b1100, 4'd3, 0, 32'h4A610000, 1'b0);
        add(3, 1'b1, 32'h0000_0000, 4'hF,    4'd4, 4, 32'h00000000, 1'b1);
        // Instance 5: Latency 8, 256 words, top word and high address bits
        add(5, 1'b0, 32'h0000_03FC, 4'hF, 4'hE, 0, 32'hC500E1FF, 1'b0);
        add(5, 1'b0, 32'hFFFF_F004, 4'hF, 4'd1, 4, 32'h6220616E, 1'b0);

        for (int t = 0; t < n_tab; t++) begin
            step();
            idle_all();
            drive(tab[t].g, tab[t].we, tab[t].addr, tab[t].be, tab[t].aid, tab[t].data, tab[t].err);
            for (int k = 0; k < tab[t].gap; k++) begin
                step();
                idle_all();
            end
        end
        repeat (12) begin step(); idle_all(); end

        // Reset in flight on instance 2: two reads accepted, reset after the
        // second edge while a third read is presented; none may answer.
        step(); idle_all(); drive(2, 1'b0, 32'h0, 4'hF, 4'd1, 32'h4A616B75, 1'b0);
        step(); idle_all(); drive(2, 1'b0, 32'h4, 4'hF, 4'd2, 32'h6220616E, 1'b0);
        step(); idle_all();
        rst_n = 1'b0;
        for (int g = 0; g < c_ncfg; g++) sb[g].delete();
        drive(2, 1'b0, 32'h8, 4'hF, 4'd3, 32'hC505E102, 1'b0);
        step(); idle_all();
        rst_n = 1'b1;
        repeat (10) begin step(); idle_all(); end

        // Random traffic on every instance at once.
        for (int c = 0; c < 400; c++) begin
            step();
            idle_all();
            for (int g = 0; g < c_ncfg; g++) begin
                logic [31:0] a;
                logic        we;
                logic [3:0]  be;
                logic [3:0]  aid;
                logic [32:0] m;
                if ($urandom_range(0, 3) != 0) begin
                    a   = $urandom();
                    if ($urandom_range(0, 1) == 1) a = a & 32'h0000_03FF;
                    we  = ($urandom_range(0, 9) == 0);
                    be  = 4'($urandom());
                    aid = 4'($urandom());
                    m   = model(g, we, a, be);
                    drive(g, we, a, be, aid, m[31:0], m[32]);
                end
            end
        end

        repeat (12) begin step(); idle_all(); end
        for (int g = 0; g < c_ncfg; g++) begin
            n_vec++;
            if (sb[g].size() != 0) begin
                n_err++;
                $display("FAIL drain[%0d]: got %0d responses outstanding, want 0", g, sb[g].size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
